// File: rtl/seq_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in over valid/ready, one bit per clock on dout.
// Optional build macro SER_PARITY_EN appends an even-parity bit after each word.
module seq_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter logic        IDLE_BIT  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
`ifdef SER_PARITY_EN
  localparam logic [CntW-1:0] CntLast   = CntW'(WIDTH);
  localparam logic [CntW-1:0] CntParity = CntW'(WIDTH - 1);
`else
  localparam logic [CntW-1:0] CntLast   = CntW'(WIDTH - 1);
`endif

  typedef enum logic {StIdle, StShift} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             busy_q, busy_d;
`ifdef SER_PARITY_EN
  logic             par_q, par_d;
`endif
  logic             accept;
  logic             load_en;
  logic [WIDTH-1:0] load_word;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // sh holds only the bits not yet presented on dout
  function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  assign data_ready = !hold_full_q && !rst;
  assign accept     = data_valid && data_ready;

  always_comb begin
    state_d      = state_q;
    sh_d         = sh_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    cnt_d        = cnt_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
`ifdef SER_PARITY_EN
    par_d        = par_q;
`endif
    load_en      = 1'b0;
    load_word    = data_in;

    unique case (state_q)
      StIdle: begin
        dout_d       = IDLE_BIT;
        dout_valid_d = 1'b0;
        if (accept) load_en = 1'b1;
      end
      StShift: begin
        if (cnt_q == CntLast) begin
          if (hold_full_q) begin
            load_en     = 1'b1;
            load_word   = hold_q;
            hold_full_d = 1'b0;
          end else if (accept) begin
            load_en = 1'b1;
          end else begin
            state_d      = StIdle;
            dout_d       = IDLE_BIT;
            dout_valid_d = 1'b0;
            cnt_d        = '0;
          end
        end else begin
          if (accept) begin
            hold_d      = data_in;
            hold_full_d = 1'b1;
          end
          cnt_d = cnt_q + 1'b1;
`ifdef SER_PARITY_EN
          if (cnt_q == CntParity) dout_d = par_q;
          else dout_d = first_bit(sh_q);
`else
          dout_d = first_bit(sh_q);
`endif
          sh_d = shift_out(sh_q);
        end
      end
      default: state_d = StIdle;
    endcase

    // Loading presents the first bit at the same edge, so there is no gap between words
    if (load_en) begin
      state_d      = StShift;
      sh_d         = shift_out(load_word);
      dout_d       = first_bit(load_word);
      dout_valid_d = 1'b1;
      cnt_d        = '0;
`ifdef SER_PARITY_EN
      par_d        = ^load_word;
`endif
    end

    busy_d = (state_d == StShift) || hold_full_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      sh_q         <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      cnt_q        <= '0;
      dout_q       <= IDLE_BIT;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
`ifdef SER_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sh_q         <= sh_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      busy_q       <= busy_d;
`ifdef SER_PARITY_EN
      par_q        <= par_d;
`endif
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_seq_serializer.sv
// Bench for seq_serializer: an MSB-first and an LSB-first instance share stimulus and are
// compared each cycle against a word/bit-queue model of the serializer.
module tb_seq_serializer;

  localparam int unsigned W = 8;
`ifdef SER_PARITY_EN
  localparam int WB = W + 1;
`else
  localparam int WB = W;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         data_valid = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         ready_m, dout_m, dv_m, busy_m;
  logic         ready_l, dout_l, dv_l, busy_l;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: bits still to appear for the current word, and accepted words not yet started
  logic         curm[$];
  logic         curl[$];
  logic [W-1:0] pend[$];
  bit           acc;
  int           vcount, run, max_run;

  always #5 clk = ~clk;

  seq_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) u_msb (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (ready_m),
    .dout       (dout_m),
    .dout_valid (dv_m),
    .busy       (busy_m)
  );

  seq_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_lsb (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (ready_l),
    .dout       (dout_l),
    .dout_valid (dv_l),
    .busy       (busy_l)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start_word(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) begin
      curm.push_back(w[W-1-i]);
      curl.push_back(w[i]);
    end
`ifdef SER_PARITY_EN
    curm.push_back(^w);
    curl.push_back(^w);
`endif
  endtask

  // One clock: drive inputs after negedge, check outputs, then advance the model at posedge
  task automatic cycle(input logic r, input logic v, input logic [W-1:0] d);
    logic exp_ready;
    logic [W-1:0] w;
    @(negedge clk);
    rst = r;
    data_valid = v;
    data_in = d;
    #1;
    exp_ready = !r && (pend.size() == 0);
    chk("ready_msb", ready_m, exp_ready);
    chk("ready_lsb", ready_l, exp_ready);
    chk("dout_msb", dout_m, (curm.size() > 0) ? curm[0] : 1'b1);
    chk("dout_lsb", dout_l, (curl.size() > 0) ? curl[0] : 1'b1);
    chk("dv_msb", dv_m, curm.size() > 0);
    chk("dv_lsb", dv_l, curl.size() > 0);
    chk("busy_msb", busy_m, (curm.size() > 0) || (pend.size() > 0));
    chk("busy_lsb", busy_l, (curl.size() > 0) || (pend.size() > 0));
    if (dv_m === 1'b1) begin
      vcount++;
      run++;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
    @(posedge clk);
    acc = 1'b0;
    if (r) begin
      curm = {};
      curl = {};
      pend = {};
    end else begin
      if (curm.size() > 0) begin
        void'(curm.pop_front());
        void'(curl.pop_front());
      end
      acc = v && exp_ready;
      if (acc) pend.push_back(d);
      if (curm.size() == 0 && pend.size() > 0) begin
        w = pend.pop_front();
        start_word(w);
      end
    end
  endtask

  initial begin
    logic [W-1:0] words[2];
    int i, guard;
    words[0] = 8'hA5;
    words[1] = 8'h3C;

    // Reset: let it take effect, then hold 3 more checked cycles and release
    @(posedge clk);
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, '0);
    cycle(1'b0, 1'b0, '0);

    // Single word 0x55
    vcount = 0;
    cycle(1'b0, 1'b1, 8'h55);
    for (int k = 0; k < WB + 3; k++) cycle(1'b0, 1'b0, '0);
    chk_int("single_word_len", vcount, WB);

    // Back-to-back with valid held high
    max_run = 0;
    run = 0;
    i = 0;
    guard = 0;
    while (i < 2 && guard < 40) begin
      cycle(1'b0, 1'b1, words[i]);
      if (acc) i++;
      guard++;
    end
    chk_int("b2b_accepted", i, 2);
    for (int k = 0; k < 2 * WB + 4; k++) cycle(1'b0, 1'b0, '0);
    chk_int("b2b_contiguous", max_run, 2 * WB);

    // Single bit word; LSB-first instance sends the set bit first
    cycle(1'b0, 1'b1, 8'h01);
    for (int k = 0; k < WB + 3; k++) cycle(1'b0, 1'b0, '0);

    // Reset during bit 3 of 0xF0 with 0x0F held
    vcount = 0;
    cycle(1'b0, 1'b1, 8'hF0);
    cycle(1'b0, 1'b1, 8'h0F);
    cycle(1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, '0);
    cycle(1'b1, 1'b0, '0);
    for (int k = 0; k < 2 * WB + 4; k++) cycle(1'b0, 1'b0, '0);
    chk_int("reset_discard", vcount, 4);

    // Random traffic with occasional reset
    for (int k = 0; k < 400; k++) begin
      cycle(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)), W'($urandom));
    end
    for (int k = 0; k < 2 * WB + 4; k++) cycle(1'b0, 1'b0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
